// File: rtl/l2_writeback_queue.sv
// l2_writeback_queue: line-granular write-back queue between the L2 memory-side
// port and the downstream pmem stage. Dirty lines are absorbed in one cycle and
// drained in the background. Read misses bypass queued writebacks, and reads
// that hit a queued line are returned from the queue.
// Optional statistics counters are enabled by defining WB_QUEUE_STATS_EN.
module l2_writeback_queue #(
   parameter int DEPTH       = 4,
   parameter int LINE_BITS   = 256,
   parameter int OFFSET_BITS = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          address,
   input  logic                 read,
   input  logic                 write,
   input  logic [LINE_BITS-1:0] wdata,
   output logic [LINE_BITS-1:0] rdata,
   output logic                 resp,
   output logic [31:0]          pmem_address,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic [LINE_BITS-1:0] pmem_wdata,
   input  logic [LINE_BITS-1:0] pmem_rdata,
   input  logic                 pmem_resp
`ifdef WB_QUEUE_STATS_EN
   ,
   output logic [31:0]          stat_read_hits,
   output logic [31:0]          stat_merges,
   output logic [31:0]          stat_full_stalls
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TAG_W = 32 - OFFSET_BITS;

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_RD_MEM, S_WR_MEM} state_t;

   state_t               state_q;
   logic [DEPTH-1:0]     valid_q;
   logic [TAG_W-1:0]     tag_q  [DEPTH];
   logic [LINE_BITS-1:0] data_q [DEPTH];
   logic [PTR_W-1:0]     head_q;
   logic [PTR_W-1:0]     tail_q;
   logic [CNT_W-1:0]     count_q;

   logic                 resp_q;
   logic [LINE_BITS-1:0] rdata_q;
   logic                 pmem_read_q;
   logic                 pmem_write_q;
   logic [31:0]          pmem_address_q;
   logic [LINE_BITS-1:0] pmem_wdata_q;

   logic [TAG_W-1:0]     req_tag;
   logic                 hit;
   logic [PTR_W-1:0]     hit_idx;
   logic                 full;
   logic                 empty;
   logic                 entry_we_d;
   logic [PTR_W-1:0]     entry_idx_d;
   logic                 unused_offset;

   assign req_tag       = address[31:OFFSET_BITS];
   assign unused_offset = ^address[OFFSET_BITS-1:0];
   assign full          = (count_q == CNT_W'(DEPTH));
   assign empty         = (count_q == '0);

   // Tag lookup across all valid entries; at most one entry can hold a given tag.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && tag_q[i] == req_tag) begin
            hit     = 1'b1;
            hit_idx = PTR_W'(i);
         end
      end
   end

   // Line write port: a merge overwrites the matching entry, a new line goes to tail.
   always_comb begin
      entry_we_d  = 1'b0;
      entry_idx_d = tail_q;
      if (!reset && state_q == S_IDLE && !read && write) begin
         if (hit) begin
            entry_we_d  = 1'b1;
            entry_idx_d = hit_idx;
         end else if (!full) begin
            entry_we_d  = 1'b1;
         end
      end
   end

   // Line storage (tag and data) written on accept or merge.
   // NOTE: tag/data arrays carry no reset; valid_q alone decides whether an entry is live.
   always_ff @(posedge clk) begin
      if (entry_we_d) begin
         data_q[entry_idx_d] <= wdata;
         tag_q[entry_idx_d]  <= req_tag;
      end
   end

   // Queue control FSM: pointers, valid bits, upstream/downstream handshakes, registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         valid_q        <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         resp_q         <= 1'b0;
         rdata_q        <= '0;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
      end else begin
         resp_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (read && hit) begin
                  rdata_q <= data_q[hit_idx];
                  resp_q  <= 1'b1;
                  state_q <= S_ACK;
               end else if (read) begin
                  pmem_read_q    <= 1'b1;
                  pmem_address_q <= {req_tag, {OFFSET_BITS{1'b0}}};
                  state_q        <= S_RD_MEM;
               end else if (write && hit) begin
                  resp_q  <= 1'b1;
                  state_q <= S_ACK;
               end else if (write && !full) begin
                  valid_q[tail_q] <= 1'b1;
                  tail_q          <= tail_q + PTR_W'(1);
                  count_q         <= count_q + CNT_W'(1);
                  resp_q          <= 1'b1;
                  state_q         <= S_ACK;
               end else if (write || !empty) begin
                  // Drain the oldest line; a stalled write is re-evaluated on return.
                  pmem_write_q   <= 1'b1;
                  pmem_address_q <= {tag_q[head_q], {OFFSET_BITS{1'b0}}};
                  pmem_wdata_q   <= data_q[head_q];
                  state_q        <= S_WR_MEM;
               end
            end
            S_ACK: begin
               state_q <= S_IDLE;
            end
            S_RD_MEM: begin
               if (pmem_resp) begin
                  rdata_q     <= pmem_rdata;
                  pmem_read_q <= 1'b0;
                  resp_q      <= 1'b1;
                  state_q     <= S_ACK;
               end
            end
            S_WR_MEM: begin
               if (pmem_resp) begin
                  valid_q[head_q] <= 1'b0;
                  head_q          <= head_q + PTR_W'(1);
                  count_q         <= count_q - CNT_W'(1);
                  pmem_write_q    <= 1'b0;
                  state_q         <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef WB_QUEUE_STATS_EN
   logic [31:0] stat_read_hits_q;
   logic [31:0] stat_merges_q;
   logic [31:0] stat_full_stalls_q;

   // Saturating event counters for queue hits, merges and full-queue write stalls.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_read_hits_q   <= '0;
         stat_merges_q      <= '0;
         stat_full_stalls_q <= '0;
      end else if (state_q == S_IDLE) begin
         if (read && hit && stat_read_hits_q != '1)
            stat_read_hits_q <= stat_read_hits_q + 32'd1;
         if (!read && write && hit && stat_merges_q != '1)
            stat_merges_q <= stat_merges_q + 32'd1;
         if (!read && write && !hit && full && stat_full_stalls_q != '1)
            stat_full_stalls_q <= stat_full_stalls_q + 32'd1;
      end
   end

   assign stat_read_hits   = stat_read_hits_q;
   assign stat_merges      = stat_merges_q;
   assign stat_full_stalls = stat_full_stalls_q;
`endif

   assign resp         = resp_q;
   assign rdata        = rdata_q;
   assign pmem_read    = pmem_read_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = pmem_address_q;
   assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_l2_writeback_queue.sv
// tb_l2_writeback_queue: directed cycle-by-cycle vectors for the write-back
// queue plus hand-written sequences for read priority, merge and reset mid-drain.
module tb_l2_writeback_queue;

   localparam logic [255:0] D0 = {8{32'hA0A0_0000}};
   localparam logic [255:0] D1 = {8{32'hB1B1_1111}};
   localparam logic [255:0] D2 = {8{32'hC2C2_2222}};
   localparam logic [255:0] D3 = {8{32'hD3D3_3333}};
   localparam logic [255:0] D4 = {8{32'hE4E4_4444}};
   localparam logic [255:0] D5 = {8{32'hF5F5_5555}};
   localparam logic [255:0] R0 = {8{32'h5EED_0000}};
   localparam logic [255:0] R1 = {8{32'h5EED_1111}};

   localparam int W_RESP   = 0;
   localparam int W_PREAD  = 1;
   localparam int W_PWRITE = 2;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  address;
   logic         read;
   logic         write;
   logic [255:0] wdata;
   logic [255:0] rdata;
   logic         resp;
   logic [31:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [255:0] pmem_wdata;
   logic [255:0] pmem_rdata;
   logic         pmem_resp;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         rd;
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wd;
      logic         presp;
      logic [255:0] prd;
      logic         e_resp;
      logic         chk_rd;
      logic [255:0] e_rdata;
      logic         e_pr;
      logic         e_pw;
      logic [31:0]  e_paddr;
      logic [255:0] e_pwd;
   } vec_t;

   vec_t vecs[$];

   l2_writeback_queue dut (
      .clk          (clk),
      .reset        (reset),
      .address      (address),
      .read         (read),
      .write        (write),
      .wdata        (wdata),
      .rdata        (rdata),
      .resp         (resp),
      .pmem_address (pmem_address),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_wdata   (pmem_wdata),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic pick(input int which);
      case (which)
         W_RESP:  return resp;
         W_PREAD: return pmem_read;
         default: return pmem_write;
      endcase
   endfunction

   task automatic wait_for(input int which, input string name);
      bit seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         if (pick(which)) seen = 1'b1;
         else tick();
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: still low after 50 cycles, required high", name);
      end
   endtask

   function automatic vec_t v(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [255:0] wd, input logic presp, input logic [255:0] prd,
                              input logic e_resp, input logic chk_rd, input logic [255:0] e_rdata,
                              input logic e_pr, input logic e_pw, input logic [31:0] e_paddr,
                              input logic [255:0] e_pwd);
      vec_t r;
      r.rd = rd; r.wr = wr; r.addr = addr; r.wd = wd; r.presp = presp; r.prd = prd;
      r.e_resp = e_resp; r.chk_rd = chk_rd; r.e_rdata = e_rdata;
      r.e_pr = e_pr; r.e_pw = e_pw; r.e_paddr = e_paddr; r.e_pwd = e_pwd;
      return r;
   endfunction

   initial begin
      int n_wr;
      int activity;

      reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; wdata = '0;
      pmem_rdata = '0; pmem_resp = 1'b0;

      // Single write, then its drain.
      vecs.push_back(v(0, 1, 32'h1000_0020, D0, 0, 0,  1, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 1, 32'h1000_0020, D0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 1, 32'h1000_0020, D0));
      vecs.push_back(v(0, 0, 0, 0, 1, 0,               0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 0, 0, 0));
      // Fill four entries back-to-back, then read-hit 0x21F.
      vecs.push_back(v(0, 1, 32'h100, D0, 0, 0,        1, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 1, 32'h200, D1, 0, 0,        0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 1, 32'h200, D1, 0, 0,        1, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 1, 32'h300, D2, 0, 0,        0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 1, 32'h300, D2, 0, 0,        1, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 1, 32'h400, D3, 0, 0,        0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 1, 32'h400, D3, 0, 0,        1, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(1, 0, 32'h21F, 0, 0, 0,         0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(1, 0, 32'h21F, 0, 0, 0,         1, 1, D1, 0, 0, 0, 0));
      // Full stall: 0x500 waits for the drain of 0x100, then lands at tail.
      vecs.push_back(v(0, 1, 32'h500, D4, 0, 0,        0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 1, 32'h500, D4, 0, 0,        0, 0, 0,  0, 1, 32'h100, D0));
      vecs.push_back(v(0, 1, 32'h500, D4, 0, 0,        0, 0, 0,  0, 1, 32'h100, D0));
      vecs.push_back(v(0, 1, 32'h500, D4, 1, 0,        0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 1, 32'h500, D4, 0, 0,        1, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(1, 0, 32'h500, 0, 0, 0,         1, 1, D4, 0, 0, 0, 0));
      // Drained line 0x100 now misses and goes to pmem.
      vecs.push_back(v(1, 0, 32'h100, 0, 0, 0,         0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(1, 0, 32'h100, 0, 0, 0,         0, 0, 0,  1, 0, 32'h100, 0));
      vecs.push_back(v(1, 0, 32'h100, 0, 1, R0,        1, 1, R0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 0, 0, 0));
      // Remaining entries drain in FIFO order across the pointer wrap.
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 1, 32'h200, D1));
      vecs.push_back(v(0, 0, 0, 0, 1, 0,               0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 1, 32'h300, D2));
      vecs.push_back(v(0, 0, 0, 0, 1, 0,               0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 1, 32'h400, D3));
      vecs.push_back(v(0, 0, 0, 0, 1, 0,               0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 1, 32'h500, D4));
      vecs.push_back(v(0, 0, 0, 0, 1, 0,               0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0,               0, 0, 0,  0, 0, 0, 0));

      // Reset state.
      tick();
      tick();
      check("reset resp", resp, 0);
      check("reset rdata", rdata, 0);
      check("reset pmem_read", pmem_read, 0);
      check("reset pmem_write", pmem_write, 0);
      check("reset pmem_address", pmem_address, 0);
      check("reset pmem_wdata", pmem_wdata, 0);
      reset = 1'b0;

      // Table-driven vectors.
      foreach (vecs[i]) begin
         read = vecs[i].rd; write = vecs[i].wr; address = vecs[i].addr; wdata = vecs[i].wd;
         pmem_resp = vecs[i].presp; pmem_rdata = vecs[i].prd;
         tick();
         check($sformatf("vec%0d resp", i), resp, vecs[i].e_resp);
         check($sformatf("vec%0d pmem_read", i), pmem_read, vecs[i].e_pr);
         check($sformatf("vec%0d pmem_write", i), pmem_write, vecs[i].e_pw);
         if (vecs[i].chk_rd)
            check($sformatf("vec%0d rdata", i), rdata, vecs[i].e_rdata);
         if (vecs[i].e_pr || vecs[i].e_pw)
            check($sformatf("vec%0d pmem_address", i), pmem_address, vecs[i].e_paddr);
         if (vecs[i].e_pw)
            check($sformatf("vec%0d pmem_wdata", i), pmem_wdata, vecs[i].e_pwd);
      end
      read = 1'b0; write = 1'b0; address = '0; wdata = '0; pmem_resp = 1'b0; pmem_rdata = '0;

      // Read priority: a read miss goes out before the queued 0x100 drains.
      write = 1'b1; address = 32'h100; wdata = D0;
      tick();
      wait_for(W_RESP, "prio write resp");
      write = 1'b0; read = 1'b1; address = 32'h800;
      tick();
      wait_for(W_PREAD, "prio pmem_read");
      check("prio no pmem_write", pmem_write, 0);
      check("prio read address", pmem_address, 32'h800);
      pmem_rdata = R1; pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      check("prio resp", resp, 1);
      check("prio rdata", rdata, R1);
      check("prio pmem_read dropped", pmem_read, 0);
      read = 1'b0; address = '0;
      wait_for(W_PWRITE, "prio drain pmem_write");
      check("prio drain address", pmem_address, 32'h100);
      check("prio drain data", pmem_wdata, D0);
      pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0;
      check("prio drain done", pmem_write, 0);
      tick();

      // Merge: second write to 0x100 replaces data in place; one drain only.
      write = 1'b1; address = 32'h100; wdata = D0;
      tick();
      wait_for(W_RESP, "merge first resp");
      wdata = D5;
      tick();
      wait_for(W_RESP, "merge second resp");
      write = 1'b0; address = '0;
      n_wr = 0;
      for (int c = 0; c < 30; c++) begin
         if (pmem_write) begin
            n_wr++;
            check("merge drain address", pmem_address, 32'h100);
            check("merge drain data", pmem_wdata, D5);
            pmem_resp = 1'b1;
         end else begin
            pmem_resp = 1'b0;
         end
         tick();
      end
      pmem_resp = 1'b0;
      check("merge drain count", n_wr, 1);

      // Reset mid-drain: queued lines are discarded, outputs clear.
      write = 1'b1; address = 32'h40; wdata = D2;
      tick();
      wait_for(W_RESP, "rst first resp");
      address = 32'h60; wdata = D3;
      tick();
      wait_for(W_RESP, "rst second resp");
      write = 1'b0; address = '0;
      wait_for(W_PWRITE, "rst drain pmem_write");
      check("rst drain address", pmem_address, 32'h40);
      reset = 1'b1;
      tick();
      check("rst pmem_write", pmem_write, 0);
      check("rst pmem_read", pmem_read, 0);
      check("rst resp", resp, 0);
      check("rst rdata", rdata, 0);
      check("rst pmem_address", pmem_address, 0);
      check("rst pmem_wdata", pmem_wdata, 0);
      reset = 1'b0;
      activity = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (pmem_read || pmem_write) activity++;
      end
      check("rst no pmem activity", activity, 0);
      read = 1'b1; address = 32'h60;
      wait_for(W_PREAD, "rst discarded line misses");
      check("rst miss address", pmem_address, 32'h60);
      pmem_rdata = R0; pmem_resp = 1'b1;
      tick();
      pmem_resp = 1'b0; read = 1'b0; address = '0;
      check("rst miss resp", resp, 1);
      check("rst miss rdata", rdata, R0);
      tick();
      tick();
      check("rst queue still empty", pmem_write, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
